bound_window_reducer: RTL and testbench
=======================================

# bound_window_reducer

Streaming reducer that folds a frame of signed constraint candidates into one feasible window, `[lower_bound, upper_bound]`, for a single variable of the MCMC solver. It is the multi-lane, multi-beat successor of the pairwise max stage. Each beat carries `LANES` candidates, and each candidate has an activation bit and a kind bit. Candidates accumulate over a frame delimited by `in_last`. The block then presents the window with per-side validity and an infeasibility flag through a valid/ready handshake.

## Interface
Parameters:
- `NUMBER_SIZE`, default 4: width of each signed candidate and of both bounds.
- `LANES`, default 4: candidates per beat (≥1; need not be a power of two).

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: the beat is present.
- `in_ready`, out, 1: the block accepts a beat. A beat is accepted on `in_valid && in_ready` at a rising edge.
- `in_last`, in, 1: the beat is the final one of the frame.
- `in_values`, in, `LANES*NUMBER_SIZE`: signed candidates. Lane i occupies bits `[i*NUMBER_SIZE +: NUMBER_SIZE]`.
- `in_activation`, in, `LANES`: 1 means the lane takes part in the reduction.
- `in_kind`, in, `LANES`: 1 means the lane is a lower-bound candidate (max-reduced). 0 means it is an upper-bound candidate (min-reduced).
- `out_valid`, out, 1: the window result is held.
- `out_ready`, in, 1: the consumer takes the result.
- `lower_bound`, out, `NUMBER_SIZE`: signed maximum of the active kind=1 candidates in the frame.
- `lower_valid`, out, 1: at least one active kind=1 candidate was seen.
- `upper_bound`, out, `NUMBER_SIZE`: signed minimum of the active kind=0 candidates in the frame.
- `upper_valid`, out, 1: at least one active kind=0 candidate was seen.
- `infeasible`, out, 1: `lower_valid && upper_valid && lower_bound > upper_bound` (signed comparison).

## Operation
- FSM has two states:
  - ACCUM (reset state). `in_ready` = 1.
  - HOLD. `in_ready` = 0 and `out_valid` = 1.
- Candidate filtering:
  - Inactive lanes are ignored whatever their value or kind.
  - Values are used as given. There is no negation and no widening.
  - All comparisons are signed, `NUMBER_SIZE` bits.
- Per accepted beat in ACCUM:
  - The lane tree gives the beat maximum of active kind=1 lanes and the beat minimum of active kind=0 lanes, each with a hit bit.
  - Accumulators update: `lower_acc = max(lower_acc, beat_max)` only when the beat hit. `upper_acc` updates the same way with min.
  - The side's valid bit ORs in the hit.
- Last beat accepted:
  - The final accumulator values, valid bits and `infeasible` are registered.
  - The state moves to HOLD at the same edge.
- Accumulator re-initialisation applies after reset and after each handshake:
  - `lower_acc` = most negative value (e.g. −8 when `NUMBER_SIZE`=4), `lower_valid` = 0.
  - `upper_acc` = most positive value (+7), `upper_valid` = 0.
- Empty side: the result carries that side's init value with its valid bit 0, and `infeasible` = 0.
- Ties: equal values leave the bound unchanged. A candidate equal to the init value still sets that side's valid bit.
- HOLD → ACCUM on `out_valid && out_ready`. Accumulators re-initialise at that edge.
- `in_valid` while in HOLD is not accepted and does not change state.
- A frame may be one beat long (`in_last` on its first beat).

## Timing
- Latency: the last beat is accepted at edge k, and `out_valid` plus results are valid from edge k onward. No beat is accepted in the cycle after edge k.
- Throughput: one beat per cycle in ACCUM. At least one HOLD cycle between frames.
- `out_valid` and the outputs stay stable in HOLD until the handshake.
- Reset values, on assertion and without a clock edge:
  - State = ACCUM.
  - `out_valid` = 0, `lower_valid` = 0, `upper_valid` = 0, `infeasible` = 0.
  - `lower_bound` = most negative, `upper_bound` = most positive.
  - `in_ready` = 0 while `reset` is high, and 1 afterwards.
- Reset mid-frame: the partial frame is discarded and no result is produced.
- Reset in HOLD: the result is dropped.

## Structure
- Package `bound_reducer_pkg`:
  - kind encodings `KIND_UPPER`=0 and `KIND_LOWER`=1;
  - state enum `{ACCUM, HOLD}`;
  - constant functions for the signed min and max of a given width.
- Sub-module `bound_lane_tree`:
  - purely combinational, parametrised by `NUMBER_SIZE` and `LANES`;
  - pairwise reduction with activation gating; an odd lane passes through unchanged;
  - outputs `beat_max`, `max_hit`, `beat_min`, `min_hit`.
- Top level holds the FSM, accumulators and output registers.

## Test plan
All scenarios use `NUMBER_SIZE`=4 and `LANES`=4.
- Single beat with last: values {3,−2,5,1}, activation 1111, kind 1010. Required: lower=5, upper=−2, both valid, `infeasible`=1, `out_valid` at the acceptance edge.
- Three-beat frame with the max in beat 2 and the min in beat 3: bounds track correctly, `in_ready` drops in HOLD, and `out_ready` held low for 3 cycles keeps the outputs stable.
- All lanes inactive: lower=−8, upper=7, both valid bits 0, `infeasible`=0.
- Boundary values: a kind=1 candidate of −8 sets `lower_valid` with lower=−8, and a kind=0 candidate of 7 sets `upper_valid`. Equal bounds 4/4 give `infeasible`=0.
- Back-to-back frames: the second frame's result does not inherit the first frame's bounds or valid bits.
- `reset` asserted mid-frame after 2 beats: outputs go to their reset values immediately, and the next frame reduces from init values.

Source files
------------

// File: rtl/bound_reducer_pkg.sv
// Shared definitions for the bound window reducer: candidate kind encodings,
// the frame FSM state type and width-generic signed range helpers.
package bound_reducer_pkg;

  // Kind bit of a candidate lane.
  localparam logic KIND_UPPER = 1'b0;  // min-reduced into the upper bound
  localparam logic KIND_LOWER = 1'b1;  // max-reduced into the lower bound

  // Frame FSM: collect beats, then hold the window until it is consumed.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Most negative two's-complement value representable in 'width' bits.
  function automatic longint signed_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  // Most positive two's-complement value representable in 'width' bits.
  function automatic longint signed_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

endpackage : bound_reducer_pkg

// File: rtl/bound_lane_tree.sv
// Combinational per-beat reduction: signed maximum of the active lower-bound
// lanes and signed minimum of the active upper-bound lanes, each with a hit bit.
// Lanes are folded pairwise level by level; an unpaired lane passes through.
module bound_lane_tree
  import bound_reducer_pkg::*;
#(
  parameter int NUMBER_SIZE = 4,
  parameter int LANES       = 4
) (
  input  logic [LANES*NUMBER_SIZE-1:0]   in_values,
  input  logic [LANES-1:0]               in_activation,
  input  logic [LANES-1:0]               in_kind,
  output logic signed [NUMBER_SIZE-1:0]  beat_max,
  output logic                           max_hit,
  output logic signed [NUMBER_SIZE-1:0]  beat_min,
  output logic                           min_hit
);

  localparam int LEVELS = $clog2(LANES);

  // One spare slot so the pair index 2*j+1 stays in range for odd lane counts.
  logic signed [NUMBER_SIZE-1:0] w_max_val [LANES+1];
  logic                          w_max_hit [LANES+1];
  logic signed [NUMBER_SIZE-1:0] w_min_val [LANES+1];
  logic                          w_min_hit [LANES+1];
  logic signed [NUMBER_SIZE-1:0] w_max_pick;
  logic signed [NUMBER_SIZE-1:0] w_min_pick;
  int                            w_count;

  // Gate lanes by activation/kind, then fold the node arrays in place.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    w_max_pick = '0;
    w_min_pick = '0;
    w_count    = LANES;
    for (int i = 0; i <= LANES; i++) begin
      w_max_val[i] = '0;
      w_max_hit[i] = 1'b0;
      w_min_val[i] = '0;
      w_min_hit[i] = 1'b0;
    end
    for (int i = 0; i < LANES; i++) begin
      w_max_val[i] = in_values[i*NUMBER_SIZE +: NUMBER_SIZE];
      w_min_val[i] = in_values[i*NUMBER_SIZE +: NUMBER_SIZE];
      w_max_hit[i] = in_activation[i] && (in_kind[i] == KIND_LOWER);
      w_min_hit[i] = in_activation[i] && (in_kind[i] == KIND_UPPER);
    end
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      // Node j only reads nodes 2j and 2j+1, which are never already overwritten.
      for (int j = 0; j < (LANES + 1) / 2; j++) begin
        if (2*j + 1 < w_count) begin
          if (w_max_hit[2*j] && w_max_hit[2*j+1])
            w_max_pick = (w_max_val[2*j+1] > w_max_val[2*j]) ? w_max_val[2*j+1] : w_max_val[2*j];
          else if (w_max_hit[2*j+1])
            w_max_pick = w_max_val[2*j+1];
          else
            w_max_pick = w_max_val[2*j];
          if (w_min_hit[2*j] && w_min_hit[2*j+1])
            w_min_pick = (w_min_val[2*j+1] < w_min_val[2*j]) ? w_min_val[2*j+1] : w_min_val[2*j];
          else if (w_min_hit[2*j+1])
            w_min_pick = w_min_val[2*j+1];
          else
            w_min_pick = w_min_val[2*j];
          w_max_hit[j] = w_max_hit[2*j] || w_max_hit[2*j+1];
          w_min_hit[j] = w_min_hit[2*j] || w_min_hit[2*j+1];
          w_max_val[j] = w_max_pick;
          w_min_val[j] = w_min_pick;
        end else if (2*j < w_count) begin
          // Unpaired last node moves down a level unchanged.
          w_max_val[j] = w_max_val[2*j];
          w_max_hit[j] = w_max_hit[2*j];
          w_min_val[j] = w_min_val[2*j];
          w_min_hit[j] = w_min_hit[2*j];
        end
      end
      w_count = (w_count + 1) / 2;
    end
  end

  assign beat_max = w_max_val[0];
  assign max_hit  = w_max_hit[0];
  assign beat_min = w_min_val[0];
  assign min_hit  = w_min_hit[0];

endmodule : bound_lane_tree

// File: rtl/bound_window_reducer.sv
// Streaming reducer folding a frame of signed candidates into one feasible
// window [lower_bound, upper_bound] with per-side validity and an
// infeasibility flag, delivered through a valid/ready handshake.
module bound_window_reducer
  import bound_reducer_pkg::*;
#(
  parameter int NUMBER_SIZE = 4,
  parameter int LANES       = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [LANES*NUMBER_SIZE-1:0]   in_values,
  input  logic [LANES-1:0]               in_activation,
  input  logic [LANES-1:0]               in_kind,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [NUMBER_SIZE-1:0]  lower_bound,
  output logic                           lower_valid,
  output logic signed [NUMBER_SIZE-1:0]  upper_bound,
  output logic                           upper_valid,
  output logic                           infeasible
);

  localparam longint                        L_MIN       = signed_min(NUMBER_SIZE);
  localparam longint                        L_MAX       = signed_max(NUMBER_SIZE);
  localparam logic signed [NUMBER_SIZE-1:0] C_LOWER_INIT = L_MIN[NUMBER_SIZE-1:0];
  localparam logic signed [NUMBER_SIZE-1:0] C_UPPER_INIT = L_MAX[NUMBER_SIZE-1:0];

  state_t                        r_state;
  state_t                        w_state_next;
  logic                          w_accept;
  logic                          w_accept_last;
  logic                          w_handshake;

  logic signed [NUMBER_SIZE-1:0] r_lower_acc;
  logic signed [NUMBER_SIZE-1:0] r_upper_acc;
  logic                          r_lower_seen;
  logic                          r_upper_seen;

  logic signed [NUMBER_SIZE-1:0] r_lower_bound;
  logic signed [NUMBER_SIZE-1:0] r_upper_bound;
  logic                          r_lower_valid;
  logic                          r_upper_valid;
  logic                          r_infeasible;

  logic signed [NUMBER_SIZE-1:0] w_beat_max;
  logic signed [NUMBER_SIZE-1:0] w_beat_min;
  logic                          w_max_hit;
  logic                          w_min_hit;
  logic signed [NUMBER_SIZE-1:0] w_lower_new;
  logic signed [NUMBER_SIZE-1:0] w_upper_new;
  logic                          w_lower_seen_new;
  logic                          w_upper_seen_new;

  bound_lane_tree #(
    .NUMBER_SIZE (NUMBER_SIZE),
    .LANES       (LANES)
  ) u_lane_tree (
    .in_values     (in_values),
    .in_activation (in_activation),
    .in_kind       (in_kind),
    .beat_max      (w_beat_max),
    .max_hit       (w_max_hit),
    .beat_min      (w_beat_min),
    .min_hit       (w_min_hit)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= ACCUM;
    else       r_state <= w_state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = !reset;
        if (in_valid && !reset && in_last) w_state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ACCUM;
      end
      default: w_state_next = ACCUM;
    endcase
  end

  assign w_accept      = in_valid && in_ready;
  assign w_accept_last = w_accept && in_last;
  assign w_handshake   = out_valid && out_ready;

  // Fold the beat into the running bounds; ties keep the current value. The
  // init values are the identities of max/min, so no seen-gating is needed.
  assign w_lower_new      = (w_max_hit && (w_beat_max > r_lower_acc)) ? w_beat_max : r_lower_acc;
  assign w_upper_new      = (w_min_hit && (w_beat_min < r_upper_acc)) ? w_beat_min : r_upper_acc;
  assign w_lower_seen_new = r_lower_seen || w_max_hit;
  assign w_upper_seen_new = r_upper_seen || w_min_hit;

  // Frame accumulators: start from the identity values, restart after each handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lower_acc  <= C_LOWER_INIT;
      r_upper_acc  <= C_UPPER_INIT;
      r_lower_seen <= 1'b0;
      r_upper_seen <= 1'b0;
    end else if (w_handshake) begin
      r_lower_acc  <= C_LOWER_INIT;
      r_upper_acc  <= C_UPPER_INIT;
      r_lower_seen <= 1'b0;
      r_upper_seen <= 1'b0;
    end else if (w_accept) begin
      r_lower_acc  <= w_lower_new;
      r_upper_acc  <= w_upper_new;
      r_lower_seen <= w_lower_seen_new;
      r_upper_seen <= w_upper_seen_new;
    end
  end

  // Result registers: capture the final window on the last beat, hold it in HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lower_bound <= C_LOWER_INIT;
      r_upper_bound <= C_UPPER_INIT;
      r_lower_valid <= 1'b0;
      r_upper_valid <= 1'b0;
      r_infeasible  <= 1'b0;
    end else if (w_accept_last) begin
      r_lower_bound <= w_lower_new;
      r_upper_bound <= w_upper_new;
      r_lower_valid <= w_lower_seen_new;
      r_upper_valid <= w_upper_seen_new;
      r_infeasible  <= w_lower_seen_new && w_upper_seen_new && (w_lower_new > w_upper_new);
    end
  end

  assign lower_bound = r_lower_bound;
  assign upper_bound = r_upper_bound;
  assign lower_valid = r_lower_valid;
  assign upper_valid = r_upper_valid;
  assign infeasible  = r_infeasible;

endmodule : bound_window_reducer

// File: tb/tb_bound_window_reducer.sv
// Directed bench for bound_window_reducer (NUMBER_SIZE=4, LANES=4).
// Beat values are written MSB lane first: {lane3, lane2, lane1, lane0}.
module tb_bound_window_reducer;

  localparam int NS = 4;
  localparam int LN = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [LN*NS-1:0]     in_values;
  logic [LN-1:0]        in_activation;
  logic [LN-1:0]        in_kind;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [NS-1:0] lower_bound;
  logic                 lower_valid;
  logic signed [NS-1:0] upper_bound;
  logic                 upper_valid;
  logic                 infeasible;

  int n_compared   = 0;
  int n_mismatched = 0;

  bound_window_reducer #(.NUMBER_SIZE(NS), .LANES(LN)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .in_values     (in_values),
    .in_activation (in_activation),
    .in_kind       (in_kind),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .lower_bound   (lower_bound),
    .lower_valid   (lower_valid),
    .upper_bound   (upper_bound),
    .upper_valid   (upper_valid),
    .infeasible    (infeasible)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [LN*NS-1:0] pk(input int l3, input int l2, input int l1, input int l0);
    return {l3[NS-1:0], l2[NS-1:0], l1[NS-1:0], l0[NS-1:0]};
  endfunction

  task automatic check_window(input string tag, input int lo, input int lv,
                              input int up, input int uv, input int inf);
    check({tag, "_lower"},      int'(lower_bound), lo);
    check({tag, "_lower_v"},    int'(lower_valid), lv);
    check({tag, "_upper"},      int'(upper_bound), up);
    check({tag, "_upper_v"},    int'(upper_valid), uv);
    check({tag, "_infeasible"}, int'(infeasible),  inf);
  endtask

  // Present one beat from the falling edge; returns #1 after the accepting edge.
  task automatic send_beat(input logic [LN*NS-1:0] vals, input logic [LN-1:0] act,
                           input logic [LN-1:0] kind, input logic last);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid      = 1'b1;
    in_last       = last;
    in_values     = vals;
    in_activation = act;
    in_kind       = kind;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Consume the held result and confirm the return to ACCUM.
  task automatic take_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_after_take"}, int'(out_valid), 0);
    check({tag, "_in_ready_after_take"},  int'(in_ready),  1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_values     = '0;
    in_activation = '0;
    in_kind       = '0;
    out_ready     = 1'b0;

    // Reset state before any clock edge.
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready",  int'(in_ready),  0);
    check_window("rst", -8, 0, 7, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // Single-beat frame: lower {3,5} -> 5, upper {-2,1} -> -2, infeasible.
    send_beat(pk(3, -2, 5, 1), 4'b1111, 4'b1010, 1'b1);
    check("single_out_valid", int'(out_valid), 1);
    check("single_in_ready",  int'(in_ready),  0);
    check_window("single", 5, 1, -2, 1, 1);
    take_result("single");

    // Three beats: beat1 lo 1 / up 3, beat2 lo 6 / up 4, beat3 lo 2 / up -5.
    send_beat(pk(1, 3, 0, 5), 4'b1111, 4'b1010, 1'b0);
    check("multi_b1_out_valid", int'(out_valid), 0);
    check("multi_b1_in_ready",  int'(in_ready),  1);
    send_beat(pk(6, 4, 2, 7), 4'b1111, 4'b1010, 1'b0);
    check("multi_b2_out_valid", int'(out_valid), 0);
    send_beat(pk(-3, -5, 2, 0), 4'b1111, 4'b1010, 1'b1);
    check("multi_out_valid", int'(out_valid), 1);
    check_window("multi", 6, 1, -5, 1, 1);
    // Offer a disruptive last beat while holding: it must be ignored.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid      = 1'b1;
      in_last       = 1'b1;
      in_values     = pk(7, -8, 7, -8);
      in_activation = 4'b1111;
      in_kind       = 4'b1010;
      #1;
      check("hold_in_ready",  int'(in_ready),  0);
      check("hold_out_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
      check_window("hold", 6, 1, -5, 1, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_result("multi");

    // All lanes inactive: both sides keep init values, invalid, feasible.
    send_beat(pk(-8, 7, 3, -1), 4'b0000, 4'b1010, 1'b1);
    check_window("empty", -8, 0, 7, 0, 0);
    take_result("empty");

    // Extremes: lower candidate -8 and upper candidate 7 still count as seen.
    send_beat(pk(-8, 7, 5, -3), 4'b1100, 4'b1000, 1'b1);
    check_window("extreme", -8, 1, 7, 1, 0);
    take_result("extreme");

    // Equal bounds 4/4 are feasible.
    send_beat(pk(4, 4, 1, 6), 4'b1111, 4'b1010, 1'b1);
    check_window("equal", 4, 1, 4, 1, 0);
    take_result("equal");

    // Back-to-back: a full window, then a lower-only frame that must not inherit it.
    send_beat(pk(3, -2, 5, 1), 4'b1111, 4'b1010, 1'b1);
    check_window("b2b_a", 5, 1, -2, 1, 1);
    take_result("b2b_a");
    send_beat(pk(2, 0, 0, 0), 4'b1000, 4'b1000, 1'b1);
    check_window("b2b_b", 2, 1, 7, 0, 0);
    take_result("b2b_b");

    // Reset after two beats of a frame: outputs snap to reset values at once.
    send_beat(pk(7, -8, 0, 0), 4'b1100, 4'b1000, 1'b0);
    send_beat(pk(6, -7, 0, 0), 4'b1100, 4'b1000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready",  int'(in_ready),  0);
    check_window("midrst", -8, 0, 7, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    // Next frame reduces from init, not from the discarded 7 / -8.
    send_beat(pk(1, 3, 0, 0), 4'b1100, 4'b1000, 1'b1);
    check("after_rst_out_valid", int'(out_valid), 1);
    check_window("after_rst", 1, 1, 3, 1, 0);
    take_result("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_bound_window_reducer
